branch_resolve_unit: RTL

//  Parametrised branch resolution + dynamic prediction for the RV32/RV64 core.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_cond_eval.sv | 37 +++
 rtl/branch_resolve_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/branch_pkg.sv
// Shared types and saturating-counter helpers for the branch resolve unit.
// Pure definitions; no timing or flow control.
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_funct3_e;

    // Widest counter supported; callers pass their real width in 'bits'.
    localparam int CTR_MAX_BITS = 8;
    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    function automatic ctr_t ctr_sat_inc(input ctr_t c, input int bits);
        ctr_t max_v;
        max_v = ctr_t'((64'd1 << bits) - 64'd1);
        return (c == max_v) ? c : c + ctr_t'(1);
    endfunction

    function automatic ctr_t ctr_sat_dec(input ctr_t c, input int bits);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Evaluates a conditional-branch funct3 on raw operands; flags reserved codes.
// Combinational, zero latency; no flow control.
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            take,
    output logic            illegal
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    always_comb begin
        take    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:     take = eq;
            BNE:     take = ~eq;
            BLT:     take = lt_s;
            BGE:     take = ~lt_s;
            BLTU:    take = lt_u;
            BGEU:    take = ~lt_u;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution with a PC-indexed saturating-counter BHT; fetch lookup is combinational.
// Results register one cycle after the resolve slot; no backpressure, one branch per cycle.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CTR_BITS    = 2,
    parameter int CTR_INIT    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_is_branch,
    input  logic [2:0]      res_funct3,
    input  logic [XLEN-1:0] res_rs1,
    input  logic [XLEN-1:0] res_rs2,
    input  logic [XLEN-1:0] res_pc,
    input  logic [XLEN-1:0] res_target,
    input  logic            res_pred_taken,
    input  logic            flush,
    output logic            out_valid,
    output logic            take_branch,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic            illegal_br,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int                  IDX_W    = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(CTR_INIT);
    localparam logic [31:0]         STAT_MAX = 32'hFFFF_FFFF;

    logic [CTR_BITS-1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0]    pred_idx;
    logic [IDX_W-1:0]    res_idx;
    logic                cond_take;
    logic                cond_illegal;
    logic                act;
    logic                legal;
    logic                mis_c;
    logic [XLEN-1:0]     next_pc;
    ctr_t                ctr_ext;
    ctr_t                ctr_nxt_w;
    logic [CTR_BITS-1:0] ctr_nxt;
    logic                unused_bits;

    assign pred_idx   = pred_pc[IDX_W+1:2];
    assign res_idx    = res_pc[IDX_W+1:2];
    // Read-before-write: a same-cycle update to this index is not bypassed.
    assign pred_taken = bht[pred_idx][CTR_BITS-1];

    branch_cond_eval #(.XLEN(XLEN)) u_cond (
        .funct3  (res_funct3),
        .rs1     (res_rs1),
        .rs2     (res_rs2),
        .take    (cond_take),
        .illegal (cond_illegal)
    );

    assign act     = res_valid & res_is_branch & ~flush;
    assign legal   = act & ~cond_illegal;
    assign mis_c   = legal & (cond_take != res_pred_taken);
    assign next_pc = res_pc + XLEN'(4);

    assign ctr_ext   = ctr_t'(bht[res_idx]);
    assign ctr_nxt_w = cond_take ? ctr_sat_inc(ctr_ext, CTR_BITS) : ctr_sat_dec(ctr_ext, CTR_BITS);
    assign ctr_nxt   = ctr_nxt_w[CTR_BITS-1:0];

    assign unused_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0], ctr_nxt_w[CTR_MAX_BITS-1:CTR_BITS]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= CTR_RST;
            end
            out_valid     <= 1'b0;
            take_branch   <= 1'b0;
            mispredict    <= 1'b0;
            illegal_br    <= 1'b0;
            redirect_pc   <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            out_valid   <= act;
            take_branch <= act & cond_take;
            mispredict  <= mis_c;
            illegal_br  <= act & cond_illegal;
            if (act) begin
                redirect_pc <= cond_take ? res_target : next_pc;
            end
            if (legal) begin
                bht[res_idx] <= ctr_nxt;
                if (stat_branches != STAT_MAX) begin
                    stat_branches <= stat_branches + 32'd1;
                end
                if (mis_c && (stat_mispred != STAT_MAX)) begin
                    stat_mispred <= stat_mispred + 32'd1;
                end
            end
        end
    end

endmodule
